// File: rtl/spi_param_pkg.sv
// Shared types and constants for the SPI parameter-write sequencer.
package spi_param_pkg;

  localparam logic [7:0] FLUSH_ADRS = 8'hFF;
  localparam logic [7:0] FLUSH_KEY  = 8'hA5;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  typedef struct packed {
    logic [7:0] adrs;
    logic [7:0] data;
  } frame_t;

  function automatic logic is_flush(input frame_t f);
    return (f.adrs == FLUSH_ADRS) && (f.data == FLUSH_KEY);
  endfunction

endpackage

// File: rtl/spi_param_fifo.sv
// Frame FIFO with wrap-bit pointers; flush can optionally keep the head entry.
module spi_param_fifo
  import spi_param_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  frame_t push_frame,
  input  logic   pop,
  input  logic   flush,
  input  logic   flush_keep_head,
  output frame_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  frame_t      mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] rd_next;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // Full is judged before any same-cycle pop, so a pop never makes room for a push.
  assign do_push = push && !full;
  assign rd_next = do_pop ? rd_ptr + PTR_ONE : rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (flush) begin
        wr_ptr <= (flush_keep_head && !empty) ? rd_ptr + PTR_ONE : rd_next;
      end else if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_frame;
  end

endmodule

// File: rtl/spi_param_ctrl.sv
// SPI frame to parameter-bus sequencer: frame detect, FIFO, req/ack FSM, error flags.
// Define SPI_PARAM_SHADOW_EN to add a readable 256x8 shadow of acknowledged writes.
module spi_param_ctrl
  import spi_param_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] adrs,
  input  logic [7:0] data,
  output logic       wr_req,
  output logic [1:0] wr_sel,
  output logic [5:0] wr_adrs,
  output logic [7:0] wr_data,
  input  logic       wr_ack,
  output logic       busy,
  output logic       overflow,
  output logic       timeout_err,
  input  logic       clr_err
`ifdef SPI_PARAM_SHADOW_EN
  ,
  input  logic [7:0] rd_adrs,
  output logic [7:0] rd_data
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rv_d;
  logic          new_frame;
  logic          flush_cmd;
  logic          push;
  logic          pop;
  logic          ack_hit;
  logic          expire;
  logic          fifo_full;
  logic          fifo_empty;
  frame_t        rx_frame;
  frame_t        head;

  assign rx_frame  = '{adrs: adrs, data: data};
  assign new_frame = rx_valid && !rv_d;
  assign flush_cmd = new_frame && is_flush(rx_frame);
  assign push      = new_frame && !flush_cmd;
  // Ack on the last allowed cycle wins over the timeout.
  assign ack_hit   = (state == REQ) && wr_ack;
  assign expire    = (state == REQ) && !wr_ack && (cnt == CNT_LAST);
  assign pop       = ack_hit || expire;
  assign busy      = !fifo_empty || (state != IDLE);

  spi_param_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk             (clk),
    .reset_n         (reset_n),
    .push            (push),
    .push_frame      (rx_frame),
    .pop             (pop),
    .flush           (flush_cmd),
    .flush_keep_head (state == REQ),
    .head            (head),
    .full            (fifo_full),
    .empty           (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv_d        <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rv_d <= rx_valid;
      if (push && fifo_full)         overflow <= 1'b1;
      else if (clr_err || flush_cmd) overflow <= 1'b0;
      if (expire)                    timeout_err <= 1'b1;
      else if (clr_err || flush_cmd) timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_req  <= 1'b0;
      wr_sel  <= '0;
      wr_adrs <= '0;
      wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {wr_sel, wr_adrs} <= head.adrs;
            wr_data           <= head.data;
            wr_req            <= 1'b1;
            cnt               <= '0;
            state             <= REQ;
          end
        end
        REQ: begin
          if (ack_hit || expire) begin
            wr_req <= 1'b0;
            state  <= GAP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_PARAM_SHADOW_EN
  logic [7:0] shadow [256];

  // Read samples the pre-update value, so a same-address update returns old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) shadow[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= shadow[rd_adrs];
      if (ack_hit) shadow[{wr_sel, wr_adrs}] <= wr_data;
    end
  end
`endif

endmodule

// File: tb/tb_spi_param_ctrl.sv
// Directed bench for spi_param_ctrl with a queue-level reference model.
module tb_spi_param_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } fr_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] adrs = '0;
  logic [7:0] data = '0;
  logic       wr_ack = 1'b0;
  logic       clr_err = 1'b0;
  logic       wr_req;
  logic [1:0] wr_sel;
  logic [5:0] wr_adrs;
  logic [7:0] wr_data;
  logic       busy;
  logic       overflow;
  logic       timeout_err;
`ifdef SPI_PARAM_SHADOW_EN
  logic [7:0] rd_adrs = '0;
  logic [7:0] rd_data;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  spi_param_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_valid    (rx_valid),
    .adrs        (adrs),
    .data        (data),
    .wr_req      (wr_req),
    .wr_sel      (wr_sel),
    .wr_adrs     (wr_adrs),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
`ifdef SPI_PARAM_SHADOW_EN
    ,
    .rd_adrs     (rd_adrs),
    .rd_data     (rd_data)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a frame queue plus the current bus transaction.
  fr_t q[$];
  fr_t m_cur, f_in, f_keep;
  bit  m_active, m_gap, m_rvd, m_ovf, m_to;
  int  m_age;
  bit  nf, fl, pushf, popf, to_set, ov_set, pre_active, pre_gap;
  int  pre_size;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_active = 0; m_gap = 0; m_rvd = 0; m_ovf = 0; m_to = 0; m_age = 0;
    end else begin
      pre_active = m_active;
      pre_gap    = m_gap;
      pre_size   = q.size();
      nf    = rx_valid && !m_rvd;
      m_rvd = rx_valid;
      f_in.a = adrs;
      f_in.d = data;
      fl     = nf && (adrs == 8'hFF) && (data == 8'hA5);
      pushf  = nf && !fl;
      ov_set = pushf && (pre_size == DEPTH);
      popf   = 0;
      to_set = 0;
      if (pre_active) begin
        m_age++;
        if (wr_ack || m_age == TMO) begin
          popf = 1; to_set = !wr_ack; m_active = 0; m_gap = 1;
        end
      end else if (pre_gap) begin
        m_gap = 0;
      end else if (pre_size > 0) begin
        m_cur = q[0]; m_active = 1; m_age = 0;
      end
      if (fl) begin
        if (pre_active && q.size() > 0) begin
          f_keep = q[0]; q.delete(); q.push_back(f_keep);
        end else begin
          q.delete();
        end
      end
      if (popf && q.size() > 0) void'(q.pop_front());
      if (pushf && pre_size < DEPTH) q.push_back(f_in);
      m_ovf = ov_set ? 1'b1 : ((clr_err || fl) ? 1'b0 : m_ovf);
      m_to  = to_set ? 1'b1 : ((clr_err || fl) ? 1'b0 : m_to);
    end
  end

  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      check("wr_req", wr_req, m_active);
      if (m_active) begin
        check("wr_sel", wr_sel, m_cur.a[7:6]);
        check("wr_adrs", wr_adrs, m_cur.a[5:0]);
        check("wr_data", wr_data, m_cur.d);
      end
      check("busy", busy, (q.size() > 0) || m_active || m_gap);
      check("overflow", overflow, m_ovf);
      check("timeout_err", timeout_err, m_to);
    end
  end

  // Ack responder and request monitor; ack_delay 0 means never acknowledge.
  int ack_delay = 0;
  int age = 0;
  int rises = 0;
  int last_len = 0;
  bit prev_req = 0;
  logic [1:0] cap_sel;
  logic [5:0] cap_adrs;
  logic [7:0] cap_data;

  always @(negedge clk) begin
    wr_ack = 1'b0;
    if (wr_req) begin
      if (!prev_req) begin
        rises++; age = 0;
        cap_sel = wr_sel; cap_adrs = wr_adrs; cap_data = wr_data;
      end
      age++;
      if (age == ack_delay) wr_ack = 1'b1;
    end else if (prev_req) begin
      last_len = age;
    end
    prev_req = wr_req;
  end

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic clr);
    @(negedge clk);
    rx_valid = 1'b1; adrs = a; data = d; clr_err = clr;
    @(negedge clk);
    rx_valid = 1'b0; clr_err = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || wr_req) && n < 300);
    check({name, "_idle_busy"}, busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: cycles=200000, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

  int r0;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_req", wr_req, 1'b0);
    check("rst_wr_sel", wr_sel, 2'd0);
    check("rst_wr_adrs", wr_adrs, 6'd0);
    check("rst_wr_data", wr_data, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    reset_n = 1'b1;
    cmp_en  = 1;

    // Single write acknowledged in the third request cycle.
    ack_delay = 3; r0 = rises;
    send_frame(8'h45, 8'h3C, 1'b0);
    wait_idle("t1");
    check("t1_reqs", rises - r0, 1);
    check("t1_sel", cap_sel, 2'd1);
    check("t1_adrs", cap_adrs, 6'h05);
    check("t1_data", cap_data, 8'h3C);
    check("t1_req_len", last_len, 3);

    // Level held high for 20 cycles is one frame.
    ack_delay = 1; r0 = rises;
    @(negedge clk);
    rx_valid = 1'b1; adrs = 8'h10; data = 8'h20;
    repeat (20) @(negedge clk);
    rx_valid = 1'b0;
    wait_idle("t2");
    check("t2_reqs", rises - r0, 1);
    check("t2_data", cap_data, 8'h20);
    check("t2_req_len", last_len, 1);

    // Six frames, no acks: overflow and timeouts.
    ack_delay = 0; r0 = rises;
    for (int i = 0; i < 6; i++) send_frame(8'h40 + 8'(i), 8'h90 + 8'(i), 1'b0);
    wait_idle("t3");
    check("t3_overflow", overflow, 1'b1);
    check("t3_timeout_err", timeout_err, 1'b1);
    check("t3_reqs_4_or_5", ((rises - r0) == 4) || ((rises - r0) == 5), 1'b1);
    check("t3_req_len", last_len, TMO);

    // Flush with one write in flight and three queued behind it.
    ack_delay = TMO; r0 = rises;
    for (int i = 0; i < 5; i++) send_frame(8'h01, 8'hA0 + 8'(i), 1'b0);
    send_frame(8'hFF, 8'hA5, 1'b0);
    wait_idle("t4");
    check("t4_reqs", rises - r0, 2);
    check("t4_last_data", cap_data, 8'hA1);
    check("t4_overflow", overflow, 1'b0);
    check("t4_timeout_err", timeout_err, 1'b0);

    // Non-key frame to 0xFF is an ordinary write.
    ack_delay = 1; r0 = rises;
    send_frame(8'hFF, 8'h5A, 1'b0);
    wait_idle("t4b");
    check("t4b_reqs", rises - r0, 1);
    check("t4b_sel", cap_sel, 2'd3);
    check("t4b_adrs", cap_adrs, 6'h3F);
    check("t4b_data", cap_data, 8'h5A);

    // clr_err coincident with the overflowing push: set wins.
    ack_delay = 0;
    for (int i = 0; i < 6; i++) send_frame(8'h20 + 8'(i), 8'h30 + 8'(i), i == 5);
    check("t5_overflow_set_wins", overflow, 1'b1);
    wait_idle("t5");
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    @(negedge clk);
    check("t5_clr_overflow", overflow, 1'b0);
    check("t5_clr_timeout", timeout_err, 1'b0);

`ifdef SPI_PARAM_SHADOW_EN
    ack_delay = 1;
    send_frame(8'h82, 8'h11, 1'b0);
    wait_idle("t6");
    @(negedge clk); rd_adrs = 8'h82;
    @(negedge clk);
    check("t6_rd_data", rd_data, 8'h11);
    ack_delay = 0;
    send_frame(8'h82, 8'h77, 1'b0);
    wait_idle("t6b");
    @(negedge clk); rd_adrs = 8'h00;
    @(negedge clk);
    check("t6_rd_untouched", rd_data, 8'h00);
    rd_adrs = 8'h82;
    @(negedge clk);
    check("t6_rd_after_timeout", rd_data, 8'h11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
